// File: rtl/scoreboard_multi.sv
// Multi-player pushbutton scoreboard: per-channel debounce and press FSM, score
// registers with saturate/wrap limits, win latch, and a rotating two-digit display.
module scoreboard_multi #(
  parameter int N_PLAYERS     = 2,
  parameter int MAX_SCORE     = 99,
  parameter int SAT_MODE      = 1,
  parameter int WIN_SCORE     = 21,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DISP_MS       = 2000
) (
  input  logic                 clk_1khz_i,
  input  logic                 rst_i,
  input  logic [N_PLAYERS-1:0] pushbutton_i,
  input  logic                 clear_i,
  output logic [6:0]           seg_tens_o,
  output logic [6:0]           seg_ones_o,
  output logic [2:0]           player_o,
  output logic                 winner_valid_o,
  output logic [2:0]           winner_o
);

  localparam int SCORE_W = $clog2(MAX_SCORE + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W  = $clog2(LONG_PRESS_MS + 1);
  localparam int DISP_W  = $clog2(DISP_MS + 1);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_LONG     = 2'd3;

  logic [N_PLAYERS-1:0] sync1_q, sync1_d;
  logic [N_PLAYERS-1:0] sync2_q, sync2_d;
  logic [N_PLAYERS-1:0] deb_q, deb_d;
  logic [DEB_W-1:0]     deb_cnt_q [N_PLAYERS];
  logic [DEB_W-1:0]     deb_cnt_d [N_PLAYERS];
  logic [1:0]           state_q [N_PLAYERS];
  logic [1:0]           state_d [N_PLAYERS];
  logic [HOLD_W-1:0]    hold_q [N_PLAYERS];
  logic [HOLD_W-1:0]    hold_d [N_PLAYERS];
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];
  logic [SCORE_W-1:0]   score_d [N_PLAYERS];
  logic [N_PLAYERS-1:0] inc_ev, dec_ev;

  logic [2:0]        player_q, player_d;
  logic [DISP_W-1:0] rot_q, rot_d;
  logic              winner_valid_q, winner_valid_d;
  logic [2:0]        winner_q, winner_d;
  logic [6:0]        seg_tens_q, seg_tens_d;
  logic [6:0]        seg_ones_q, seg_ones_d;

  logic              win_hit, apply, any_ev;
  logic [2:0]        win_idx, ev_idx;
  logic [SCORE_W-1:0] disp_score;
  logic [6:0]        disp7;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      sync1_d[i]   = pushbutton_i[i];
      sync2_d[i]   = sync1_q[i];
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_MS - 1))
          deb_d[i] = sync2_q[i];
        else
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      // IDLE is only entered with the debounced level low, so a high level there is a rise
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      inc_ev[i]  = 1'b0;
      dec_ev[i]  = 1'b0;
      case (state_q[i])
        ST_DISARMED: if (!deb_q[i]) state_d[i] = ST_IDLE;
        ST_IDLE: begin
          if (deb_q[i]) begin
            state_d[i] = ST_PRESSED;
            hold_d[i]  = '0;
          end
        end
        ST_PRESSED: begin
          if (!deb_q[i]) begin
            state_d[i] = ST_IDLE;
            inc_ev[i]  = 1'b1;
          end else if (hold_q[i] == HOLD_W'(LONG_PRESS_MS - 1)) begin
            state_d[i] = ST_LONG;
            dec_ev[i]  = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        ST_LONG: if (!deb_q[i]) state_d[i] = ST_IDLE;
        default: state_d[i] = ST_DISARMED;
      endcase
      if (clear_i) state_d[i] = ST_DISARMED;
    end
  end

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    any_ev  = 1'b0;
    ev_idx  = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (WIN_SCORE != 0 && score_q[i] == SCORE_W'(WIN_SCORE)) begin
        win_hit = 1'b1;
        win_idx = 3'(i);
      end
    end
    // A score sitting at WIN_SCORE freezes the board even before the latch is visible
    apply = !clear_i && !winner_valid_q && !win_hit;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (apply && (inc_ev[i] || dec_ev[i])) begin
        any_ev = 1'b1;
        ev_idx = 3'(i);
      end
    end

    for (int i = 0; i < N_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      if (clear_i) begin
        score_d[i] = '0;
      end else if (apply && inc_ev[i]) begin
        if (score_q[i] != SCORE_W'(MAX_SCORE))
          score_d[i] = score_q[i] + 1'b1;
        else if (SAT_MODE == 0)
          score_d[i] = '0;
      end else if (apply && dec_ev[i]) begin
        if (score_q[i] != '0)
          score_d[i] = score_q[i] - 1'b1;
        else if (SAT_MODE == 0)
          score_d[i] = SCORE_W'(MAX_SCORE);
      end
    end

    winner_valid_d = winner_valid_q;
    winner_d       = winner_q;
    if (clear_i) begin
      winner_valid_d = 1'b0;
      winner_d       = '0;
    end else if (!winner_valid_q && win_hit) begin
      winner_valid_d = 1'b1;
      winner_d       = win_idx;
    end

    player_d = player_q;
    rot_d    = rot_q + 1'b1;
    if (winner_valid_d) begin
      player_d = winner_d;
      rot_d    = '0;
    end else if (any_ev) begin
      player_d = ev_idx;
      rot_d    = '0;
    end else if (rot_q == DISP_W'(DISP_MS - 1)) begin
      rot_d    = '0;
      player_d = (player_q == 3'(N_PLAYERS - 1)) ? 3'd0 : player_q + 1'b1;
    end

    disp_score = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (player_q == 3'(i)) disp_score = score_q[i];
    end
    disp7      = 7'(disp_score);
    seg_tens_d = seg7(4'(disp7 / 7'd10));
    seg_ones_d = seg7(4'(disp7 % 7'd10));
  end

  // Synchronisers and debounced levels reset high so a button held through reset stays disarmed
  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      deb_q          <= '1;
      for (int i = 0; i < N_PLAYERS; i++) begin
        deb_cnt_q[i] <= '0;
        state_q[i]   <= ST_DISARMED;
        hold_q[i]    <= '0;
        score_q[i]   <= '0;
      end
      player_q       <= '0;
      rot_q          <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
      seg_tens_q     <= 7'h40;
      seg_ones_q     <= 7'h40;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      for (int i = 0; i < N_PLAYERS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        state_q[i]   <= state_d[i];
        hold_q[i]    <= hold_d[i];
        score_q[i]   <= score_d[i];
      end
      player_q       <= player_d;
      rot_q          <= rot_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
      seg_tens_q     <= seg_tens_d;
      seg_ones_q     <= seg_ones_d;
    end
  end

  assign seg_tens_o     = seg_tens_q;
  assign seg_ones_o     = seg_ones_q;
  assign player_o       = player_q;
  assign winner_valid_o = winner_valid_q;
  assign winner_o       = winner_q;

endmodule

// File: tb/tb_scoreboard_multi.sv
// Scoreboard bench: stimulus queues time-stamped expected display states, a monitor
// compares them against three differently parameterised scoreboard_multi instances.
module tb_scoreboard_multi;

  typedef struct {
    int         due;
    int         dut;
    logic [6:0] tens;
    logic [6:0] ones;
    logic [2:0] player;
    bit         chk_player;
    logic       wv;
    logic [2:0] win;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];
  int   s0[2];
  int   c, rel, cr;

  logic       rst0, rst1, rst2, clr0, clr1, clr2;
  logic [1:0] btn0, btn2;
  logic [2:0] btn1;
  logic [6:0] tens0, ones0, tens1, ones1, tens2, ones2;
  logic [2:0] player0, player1, player2, win0, win1, win2;
  logic       wv0, wv1, wv2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scoreboard_multi u0 (
    .clk_1khz_i(clk), .rst_i(rst0), .pushbutton_i(btn0), .clear_i(clr0),
    .seg_tens_o(tens0), .seg_ones_o(ones0), .player_o(player0),
    .winner_valid_o(wv0), .winner_o(win0)
  );

  scoreboard_multi #(.N_PLAYERS(3), .SAT_MODE(0), .WIN_SCORE(0)) u1 (
    .clk_1khz_i(clk), .rst_i(rst1), .pushbutton_i(btn1), .clear_i(clr1),
    .seg_tens_o(tens1), .seg_ones_o(ones1), .player_o(player1),
    .winner_valid_o(wv1), .winner_o(win1)
  );

  scoreboard_multi #(.SAT_MODE(1), .WIN_SCORE(0)) u2 (
    .clk_1khz_i(clk), .rst_i(rst2), .pushbutton_i(btn2), .clear_i(clr2),
    .seg_tens_o(tens2), .seg_ones_o(ones2), .player_o(player2),
    .winner_valid_o(wv2), .winner_o(win2)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic pushExpect(input int dut, input int due, input int score, input int player,
                            input bit chk_player, input logic wv, input int win, input string name);
    exp_t e;
    e.due = due;
    e.dut = dut;
    e.tens = segOf(score / 10);
    e.ones = segOf(score % 10);
    e.player = 3'(player);
    e.chk_player = chk_player;
    e.wv = wv;
    e.win = 3'(win);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] at, ao;
    logic [2:0] ap, aw;
    logic       av;
    case (e.dut)
      0:       begin at = tens0; ao = ones0; ap = player0; av = wv0; aw = win0; end
      1:       begin at = tens1; ao = ones1; ap = player1; av = wv1; aw = win1; end
      default: begin at = tens2; ao = ones2; ap = player2; av = wv2; aw = win2; end
    endcase
    n_compared++;
    if (e.due != cyc) begin
      n_mismatched++;
      $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
    end else if (at !== e.tens || ao !== e.ones || av !== e.wv || aw !== e.win ||
                 (e.chk_player && ap !== e.player)) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0d: got tens=%h ones=%h player=%0d wv=%0b win=%0d, required tens=%h ones=%h player=%0d wv=%0b win=%0d",
               e.name, cyc, at, ao, ap, av, aw, e.tens, e.ones, e.player, e.wv, e.win);
    end
  endtask

  // Monitor: compare every expectation whose cycle has come, away from the active edge
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setButtons(input int dut, input logic [2:0] mask, output int at);
    @(negedge clk);
    case (dut)
      0:       btn0 = mask[1:0];
      1:       btn1 = mask;
      default: btn2 = mask[1:0];
    endcase
    at = cyc;
  endtask

  task automatic applyStimulus(input int dut, input logic [2:0] mask, input int hold, output int rel_at);
    int start;
    setButtons(dut, mask, start);
    repeat (hold - 1) @(negedge clk);
    setButtons(dut, 3'b000, rel_at);
  endtask

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    clr0 = 0; clr1 = 0; clr2 = 0;
    btn0 = 2'b01; btn1 = '0; btn2 = '0;
    s0[0] = 0; s0[1] = 0;

    repeat (3) @(negedge clk);
    pushExpect(0, cyc + 1, 0, 0, 1, 0, 0, "u0 reset state");
    pushExpect(1, cyc + 1, 0, 0, 1, 0, 0, "u1 reset state");
    repeat (2) @(negedge clk);
    rst0 = 0;

    // Button 0 held through reset must not score
    waitCycles(45);
    setButtons(0, 3'b000, c);
    pushExpect(0, c + 30, 0, 0, 1, 0, 0, "held through reset");
    waitCycles(40);
    applyStimulus(0, 3'b001, 100, rel);
    pushExpect(0, rel + 23, 0, 0, 1, 0, 0, "seg before update");
    s0[0] = 1;
    pushExpect(0, rel + 24, 1, 0, 1, 0, 0, "first press");
    waitCycles(30);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 3'b010, 40, rel);
      s0[1]++;
      pushExpect(0, rel + 24, s0[1], 1, 1, 0, 0, "p1 short press");
      waitCycles(30);
    end

    // Long press of player 1 from 5
    setButtons(0, 3'b010, c);
    pushExpect(0, c + 1023, 5, 1, 1, 0, 0, "long press before dec");
    pushExpect(0, c + 1024, 4, 1, 1, 0, 0, "long press dec");
    s0[1] = 4;
    waitCycles(1199);
    setButtons(0, 3'b000, rel);
    pushExpect(0, rel + 24, 4, 1, 1, 0, 0, "no inc after long");
    waitCycles(30);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 3'b011, 40, rel);
      s0[0]++; s0[1]++;
      pushExpect(0, rel + 24, s0[0], 0, 1, 0, 0, "joint press lowest idx");
      waitCycles(30);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 3'b001, 40, rel);
      s0[0]++;
      pushExpect(0, rel + 24, s0[0], 0, 1, 0, 0, "p0 to twenty");
      waitCycles(30);
    end

    applyStimulus(0, 3'b011, 40, rel);
    pushExpect(0, rel + 23, 20, 0, 1, 0, 0, "win pre-latch");
    pushExpect(0, rel + 24, 21, 0, 1, 1, 0, "win latched p0");
    waitCycles(30);
    applyStimulus(0, 3'b010, 40, rel);
    pushExpect(0, rel + 30, 21, 0, 1, 1, 0, "frozen after win");
    pushExpect(0, rel + 2100, 21, 0, 1, 1, 0, "rotation stopped");
    waitCycles(2101);

    @(negedge clk);
    clr0 = 1;
    c = cyc;
    pushExpect(0, c + 1, 21, 0, 1, 0, 0, "clear winner drop");
    pushExpect(0, c + 2, 0, 0, 1, 0, 0, "clear seg zero");
    @(negedge clk);
    clr0 = 0;
    waitCycles(5);
    applyStimulus(0, 3'b010, 40, rel);
    pushExpect(0, rel + 24, 1, 1, 1, 0, 0, "press after clear");
    waitCycles(30);
    applyStimulus(0, 3'b001, 5, rel);
    pushExpect(0, rel + 40, 1, 1, 1, 0, 0, "glitch ignored");
    waitCycles(45);

    // Rotation with three players, then wrap-mode limits
    @(negedge clk);
    rst1 = 0;
    cr = cyc;
    pushExpect(1, cr + 1999, 0, 0, 1, 0, 0, "rotate hold 0");
    pushExpect(1, cr + 2000, 0, 1, 1, 0, 0, "rotate to 1");
    pushExpect(1, cr + 4000, 0, 2, 1, 0, 0, "rotate to 2");
    pushExpect(1, cr + 6000, 0, 0, 1, 0, 0, "rotate back to 0");
    waitCycles(6005);
    setButtons(1, 3'b100, c);
    pushExpect(1, c + 1024, 99, 2, 1, 0, 0, "wrap dec from 0");
    waitCycles(1099);
    setButtons(1, 3'b000, rel);
    pushExpect(1, rel + 24, 99, 2, 1, 0, 0, "wrap long release");
    waitCycles(30);
    applyStimulus(1, 3'b100, 40, rel);
    pushExpect(1, rel + 24, 0, 2, 1, 0, 0, "wrap inc from 99");
    waitCycles(30);

    // Saturating limits
    @(negedge clk);
    rst2 = 0;
    waitCycles(30);
    for (int k = 1; k <= 100; k++) begin
      applyStimulus(2, 3'b001, 25, rel);
      pushExpect(2, rel + 24, (k > 99) ? 99 : k, 0, 1, 0, 0, (k > 99) ? "saturate at 99" : "sat count up");
      waitCycles(25);
    end
    setButtons(2, 3'b010, c);
    pushExpect(2, c + 1024, 0, 1, 0, 0, 0, "saturate dec at 0");
    waitCycles(1049);
    setButtons(2, 3'b000, rel);
    waitCycles(30);

    if (exp_q.size() != 0) begin
      foreach (exp_q[i]) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: never checked, due cycle %0d, now %0d", exp_q[i].name, exp_q[i].due, cyc);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
